// File: rtl/uart_tx.sv
// 8N1 serial transmitter (configurable stop bits) with a one-byte holding buffer
// so consecutive frames go out with no idle gap.
module uart_tx #(
  parameter int CYCLES_PER_BIT = 4,
  parameter int STOP_BITS      = 1
) (
  input  logic       clk_4x,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_serial,
  output logic       out_busy
);

  localparam int STOP_CYCLES = STOP_BITS * CYCLES_PER_BIT;
  localparam int CW          = $clog2(STOP_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  buf_data;
  logic        buf_full;
  logic        load;
  logic        serial_n;

  assign in_ready = !buf_full && !rst;
  assign out_busy = (state != IDLE) || buf_full;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    load      = 1'b0;
    serial_n  = 1'b1;
    case (state)
      IDLE: begin
        if (buf_full) begin
          state_n = START;
          cnt_n   = BIT_LAST;
          shift_n = buf_data;
          load    = 1'b1;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_n   = DATA;
          cnt_n     = BIT_LAST;
          bit_idx_n = 3'd0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_n = shift >> 1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            cnt_n   = STOP_LAST;
          end else begin
            cnt_n     = BIT_LAST;
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        // Chain straight into the buffered byte so frames stay contiguous.
        if (cnt == '0) begin
          if (buf_full) begin
            state_n = START;
            cnt_n   = BIT_LAST;
            shift_n = buf_data;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // The line value is decided from the next state so out_serial can be a plain flop.
    case (state_n)
      START:   serial_n = 1'b0;
      DATA:    serial_n = shift_n[0];
      default: serial_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_4x) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
      buf_data   <= 8'd0;
      buf_full   <= 1'b0;
      out_serial <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      out_serial <= serial_n;
      if (load) begin
        buf_full <= 1'b0;
      end else if (in_valid && in_ready) begin
        buf_full <= 1'b1;
        buf_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed steps on a default and a two-stop-bit instance, with a
// serial frame decoder fed by a scoreboard of accepted bytes.
module tb_uart_tx;

  logic       clk_4x = 1'b0;
  logic       rst1, rst2;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       ready1, ready2;
  logic       serial1, serial2;
  logic       busy1, busy2;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [7:0] exp_q [2][$];
  int         gaps  [2][$];
  int         frames   [2];
  int         accepts  [2];
  bit         dec_active [2];
  int         dec_off    [2];
  int         last_start [2];
  logic [7:0] dec_byte   [2];

  always #5 clk_4x = ~clk_4x;

  uart_tx #(.CYCLES_PER_BIT(4), .STOP_BITS(1)) dut1 (
    .clk_4x(clk_4x), .rst(rst1), .in_data(data1), .in_valid(valid1),
    .in_ready(ready1), .out_serial(serial1), .out_busy(busy1)
  );

  uart_tx #(.CYCLES_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk_4x(clk_4x), .rst(rst2), .in_data(data2), .in_valid(valid2),
    .in_ready(ready2), .out_serial(serial2), .out_busy(busy2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else return 1'b1;
  endfunction

  // Scoreboard push on accept, and a mid-bit sampling decoder per instance.
  always @(posedge clk_4x) begin
    logic s, r, v, rdy;
    logic [7:0] dat;
    int sb;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      s   = (d == 0) ? serial1 : serial2;
      r   = (d == 0) ? rst1    : rst2;
      v   = (d == 0) ? valid1  : valid2;
      rdy = (d == 0) ? ready1  : ready2;
      dat = (d == 0) ? data1   : data2;
      sb  = (d == 0) ? 1 : 2;
      if (r) begin
        exp_q[d].delete();
        dec_active[d] = 1'b0;
      end else begin
        if (v && rdy) begin
          exp_q[d].push_back(dat);
          accepts[d]++;
        end
        if (!dec_active[d]) begin
          if (s == 1'b0) begin
            dec_active[d] = 1'b1;
            dec_off[d]    = 0;
            gaps[d].push_back(cyc - last_start[d]);
            last_start[d] = cyc;
          end
        end else begin
          dec_off[d]++;
        end
        if (dec_active[d]) begin
          if (dec_off[d] == 2) checkOutput("start_bit", s, 1'b0);
          for (int i = 0; i < 8; i++)
            if (dec_off[d] == 4*(i+1) + 2) dec_byte[d][i] = s;
          if (dec_off[d] == 38 || dec_off[d] == 42) checkOutput("stop_bit", s, 1'b1);
          if (dec_off[d] == 34 + 4*sb) begin
            dec_active[d] = 1'b0;
            frames[d]++;
            checkOutput("frame_expected", exp_q[d].size() > 0, 1'b1);
            if (exp_q[d].size() > 0) checkOutput("rx_byte", dec_byte[d], exp_q[d].pop_front());
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int which, input logic [7:0] d);
    int waited = 0;
    @(negedge clk_4x);
    while (!((which == 0) ? ready1 : ready2) && waited < 200) begin
      @(negedge clk_4x);
      waited++;
    end
    if (waited >= 200) begin
      checkOutput("ready_timeout", waited, 0);
    end else begin
      if (which == 0) begin valid1 = 1'b1; data1 = d; end
      else            begin valid2 = 1'b1; data2 = d; end
      @(negedge clk_4x);
      valid1 = 1'b0;
      valid2 = 1'b0;
    end
  endtask

  task automatic waitIdle(input int which);
    int waited = 0;
    while (((which == 0) ? busy1 : busy2) && waited < 1000) begin
      @(negedge clk_4x);
      waited++;
    end
    checkOutput("idle_timeout", waited < 1000, 1'b1);
    repeat (4) @(negedge clk_4x);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f0, a0;
    logic [7:0] burst [4];
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h5A; burst[3] = 8'hC3;
    for (int d = 0; d < 2; d++) begin
      frames[d] = 0; accepts[d] = 0; dec_active[d] = 1'b0; dec_off[d] = 0;
      last_start[d] = 0; dec_byte[d] = 8'h00;
    end
    rst1 = 1'b1; rst2 = 1'b1;
    valid1 = 1'b0; valid2 = 1'b0; data1 = 8'h00; data2 = 8'h00;

    $display("[TB] reset and idle");
    repeat (3) begin
      @(negedge clk_4x);
      checkOutput("rst_ready", ready1, 1'b0);
      checkOutput("rst_serial", serial1, 1'b1);
      checkOutput("rst_busy", busy1, 1'b0);
      checkOutput("rst_serial2", serial2, 1'b1);
    end
    rst1 = 1'b0; rst2 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_4x);
      checkOutput("idle_ready", ready1, 1'b1);
      checkOutput("idle_serial", serial1, 1'b1);
      checkOutput("idle_busy", busy1, 1'b0);
    end

    $display("[TB] single byte 0xA5");
    applyStimulus(0, 8'hA5);
    checkOutput("a5_busy", busy1, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_4x);
      checkOutput("a5_line", serial1, frameBit(8'hA5, (k-1)/4));
    end
    @(negedge clk_4x);
    checkOutput("a5_busy_end", busy1, 1'b0);
    checkOutput("a5_line_end", serial1, 1'b1);
    repeat (4) @(negedge clk_4x);

    $display("[TB] back-to-back 0x00 then 0xFF");
    @(negedge clk_4x);
    valid1 = 1'b1; data1 = 8'h00;
    @(negedge clk_4x);
    checkOutput("b2b_ready_low", ready1, 1'b0);
    data1 = 8'hFF;
    @(negedge clk_4x);
    checkOutput("b2b_ready_back", ready1, 1'b1);
    checkOutput("b2b_line", serial1, 1'b0);
    @(negedge clk_4x);
    checkOutput("b2b_ready_full", ready1, 1'b0);
    valid1 = 1'b0;
    checkOutput("b2b_line", serial1, 1'b0);
    for (int k = 3; k <= 80; k++) begin
      @(negedge clk_4x);
      checkOutput("b2b_line", serial1,
                  (k <= 40) ? frameBit(8'h00, (k-1)/4) : frameBit(8'hFF, (k-41)/4));
    end
    @(negedge clk_4x);
    checkOutput("b2b_busy_end", busy1, 1'b0);
    checkOutput("b2b_line_end", serial1, 1'b1);
    repeat (4) @(negedge clk_4x);

    $display("[TB] overrun guard 0x3C");
    f0 = frames[0]; a0 = accepts[0];
    valid1 = 1'b1; data1 = 8'h3C;
    repeat (200) begin
      @(negedge clk_4x);
      if (!busy1) checkOutput("ovr_busy", busy1, 1'b1);
    end
    valid1 = 1'b0;
    waitIdle(0);
    checkOutput("ovr_accepts", accepts[0] - a0, 6);
    checkOutput("ovr_frames", frames[0] - f0, 6);
    checkOutput("ovr_queue_empty", exp_q[0].size(), 0);

    $display("[TB] reset mid-frame 0x55");
    applyStimulus(0, 8'h55);
    repeat (18) @(negedge clk_4x);
    rst1 = 1'b1;
    @(negedge clk_4x);
    checkOutput("mid_rst_line", serial1, 1'b1);
    checkOutput("mid_rst_busy", busy1, 1'b0);
    checkOutput("mid_rst_ready", ready1, 1'b0);
    @(negedge clk_4x);
    rst1 = 1'b0;
    f0 = frames[0];
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_4x);
      if (serial1 !== 1'b1) checkOutput("mid_rst_quiet", serial1, 1'b1);
    end
    checkOutput("mid_rst_no_frame", frames[0] - f0, 0);
    applyStimulus(0, 8'h55);
    waitIdle(0);
    checkOutput("mid_rst_resend", frames[0] - f0, 1);

    $display("[TB] loopback burst, one stop bit");
    f0 = frames[0];
    gaps[0].delete();
    for (int i = 0; i < 4; i++) applyStimulus(0, burst[i]);
    waitIdle(0);
    checkOutput("lb1_frames", frames[0] - f0, 4);
    checkOutput("lb1_queue_empty", exp_q[0].size(), 0);
    checkOutput("lb1_gap_count", gaps[0].size(), 4);
    for (int i = 1; i < 4 && i < gaps[0].size(); i++) checkOutput("lb1_gap", gaps[0][i], 40);

    $display("[TB] loopback burst, two stop bits");
    f0 = frames[1];
    gaps[1].delete();
    for (int i = 0; i < 4; i++) applyStimulus(1, burst[i]);
    waitIdle(1);
    checkOutput("lb2_frames", frames[1] - f0, 4);
    checkOutput("lb2_queue_empty", exp_q[1].size(), 0);
    checkOutput("lb2_gap_count", gaps[1].size(), 4);
    for (int i = 1; i < 4 && i < gaps[1].size(); i++) checkOutput("lb2_gap", gaps[1][i], 44);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter paired with the existing 4x-oversampled UART receiver.
- Takes bytes over a valid/ready handshake and drives an 8N1 frame (stop-bit count is configurable) on one serial line.
- Line format: idle high, one start bit (low), 8 data bits LSB first, stop bit(s) high, each bit held CYCLES_PER_BIT clocks.
- A one-byte holding buffer lets the next byte be accepted while the current frame shifts, so back-to-back frames have no idle gap.

Parameters:
- CYCLES_PER_BIT, 4, clocks per serial bit; 4 matches the receiver on the shared clk_4x. Legal range is ≥2.
- STOP_BITS, 1, number of stop bits per frame; legal values are 1 or 2.

Ports:
- clk_4x  input  1  clock, 4x the baud rate at default parameters
- rst  input  1  synchronous, active-high reset
- in_data  input  8  byte to transmit
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  holding buffer is empty; a byte is accepted when in_valid && in_ready at a rising edge
- out_serial  output  1  serial line, registered
- out_busy  output  1  a frame is in progress or a byte is waiting in the holding buffer

Behaviour:
- Reset, sampled on the clk_4x rising edge while rst=1:
  - state goes to IDLE, all counters go to 0, and the buffer goes empty.
  - out_serial=1 and out_busy=0.
  - in_ready=0 while rst=1, and in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-frame aborts the frame immediately: the line returns high on the next edge and any buffered byte is discarded.
- in_ready = !buf_full && !rst. It is combinational from registers and does not depend on in_valid.
- Accept: on an edge where in_valid && in_ready, in_data goes into the holding buffer and buf_full=1. in_data is don't-care when in_valid=0.
- States and transitions. Each state runs a cycle counter from CYCLES_PER_BIT-1 down to 0.
  - IDLE: out_serial=1. If buf_full, go to START on the next edge: the buffer moves into the shift register and buf_full clears.
  - START: out_serial=0 for CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: out_serial=shift[0] for each bit. The register shifts right after each bit; 8 bits are sent, then go to STOP.
  - STOP: out_serial=1 for STOP_BITS*CYCLES_PER_BIT cycles. On the last STOP cycle:
    - if buf_full, load the buffer and go directly to START (no idle cycle);
    - otherwise go to IDLE.
- Latency: a byte accepted at edge N into an idle transmitter drives out_serial low from edge N+1.
- Frame length is (9+STOP_BITS)*CYCLES_PER_BIT cycles: 40 at the defaults.
- Buffer timing:
  - A buffer load and a new accept never coincide, because in_ready is low while the buffer is full.
  - in_ready rises the cycle after the buffer is transferred to the shift register.
  - So a byte can be accepted during START of the frame being shifted, and it transmits back-to-back.
- out_busy = (state != IDLE) || buf_full.
- Counter widths are $clog2 of their maximum count. Wrap-around is not permitted; every counter is reloaded at each state transition.
- out_serial comes straight from a flop, with no combinational path from the inputs.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then release and hold in_valid=0 for 100 cycles → out_serial=1 throughout, out_busy=0, and in_ready=0 during reset then 1 after.
- Single byte 0xA5 at defaults → starting the edge after accept, out_serial carries 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - Total 40 cycles, then the line stays high and out_busy falls at cycle 41.
- Back-to-back 0x00 then 0xFF, second presented with in_valid held high:
  - in_ready deasserts for exactly one cycle after the first accept (the idle buffer-to-shift-register load), then reasserts;
  - the second byte is accepted during START of the first frame;
  - the frames are contiguous over 80 cycles, with no extra high cycle between the stop bit and the next start.
- Overrun guard: hold in_valid=1 with 0x3C for 200 cycles → each accepted byte is sent exactly once per frame, and in_ready stays low while the buffer is full.
- Reset mid-frame: assert rst during DATA bit 3 of 0x55 → out_serial=1 on the next edge and no residual frame follows. A new byte after release transmits correctly.
- Loopback: connect out_serial to the receiver's in_serial and send 0x00, 0xFF, 0x5A, 0xC3 back-to-back → receiver out_data matches each byte with one out_valid pulse per byte.
  - Repeat with STOP_BITS=2: the frame is 44 cycles and all bytes are still received.
